// File: rtl/tdm_pkg.sv
// Shared types for the time-division neuron scheduler.
package tdm_pkg;

   typedef enum logic [2:0] {
      INIT  = 3'd0,
      IDLE  = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/tdm_state_ram.sv
// Per-neuron {v,w} state store: one write port, one synchronous read port.
// Only the read-data register is reset; the array contents are not.
module tdm_state_ram
   import tdm_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q, rdata_d;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem_q[raddr];
      end else begin
         rdata_d = rdata_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/tdm_neuron_scheduler.sv
// Time-division scheduler feeding one pipelined neuron core from a state RAM.
// Optional write-back monitor port enabled by defining TDM_MONITOR_EN.
module tdm_neuron_scheduler
   import tdm_pkg::*;
#(
   parameter int                NEURON_COUNT = 500,
   parameter int                PIPE_DEPTH   = 5,
   parameter int                DATA_W       = 16,
   parameter logic [DATA_W-1:0] V_INIT       = 16'hECE1,
   parameter logic [DATA_W-1:0] W_INIT       = 16'hF600,
   parameter logic [DATA_W-1:0] V_THRESH     = 16'h1E00,
   localparam int               IDX_W        = $clog2(NEURON_COUNT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              step_start,
   output logic              step_busy,
   output logic              step_done,
   output logic              step_overrun,
   output logic [31:0]       step_count,
   output logic [IDX_W-1:0]  stim_addr,
   input  logic [DATA_W-1:0] stim_data,
   output logic              core_valid,
   output logic [DATA_W-1:0] core_v,
   output logic [DATA_W-1:0] core_w,
   output logic [DATA_W-1:0] core_i,
   input  logic [DATA_W-1:0] core_v_out,
   input  logic [DATA_W-1:0] core_w_out,
   output logic              spike_valid,
   output logic [IDX_W-1:0]  spike_idx
`ifdef TDM_MONITOR_EN
   ,input  logic [IDX_W-1:0]  monitor_id
   ,output logic [DATA_W-1:0] mon_v
   ,output logic [DATA_W-1:0] mon_w
   ,output logic              mon_valid
`endif
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NEURON_COUNT - 1);

   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
   } tag_t;

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        init_idx_q, init_idx_d;
   logic [IDX_W-1:0]        issue_idx_q, issue_idx_d;
   tag_t [PIPE_DEPTH:0]     pipe_q, pipe_d;
   logic                    step_busy_q, step_busy_d;
   logic                    step_done_q, step_done_d;
   logic                    step_overrun_q, step_overrun_d;
   logic [31:0]             step_count_q, step_count_d;
   logic                    spike_valid_q, spike_valid_d;
   logic [IDX_W-1:0]        spike_idx_q, spike_idx_d;
   logic                    pipe_busy_s, spike_hit_s;
   tag_t                    tail_s;
   logic                    ram_we_s, ram_re_s;
   logic [IDX_W-1:0]        ram_waddr_s;
   logic [2*DATA_W-1:0]     ram_wdata_s, ram_rdata_s;

   // Tag pipe mirrors the core latency; stage 0 lines up with core_valid.
   always_comb begin
      pipe_d          = pipe_q;
      pipe_d[0].valid = (state_q == RUN);
      pipe_d[0].idx   = issue_idx_q;
      for (int j = 1; j <= PIPE_DEPTH; j++) begin
         pipe_d[j] = pipe_q[j-1];
      end
      pipe_busy_s = 1'b0;
      for (int j = 0; j < PIPE_DEPTH; j++) begin
         pipe_busy_s = pipe_busy_s | pipe_q[j].valid;
      end
      tail_s      = pipe_q[PIPE_DEPTH];
      spike_hit_s = tail_s.valid && ($signed(core_v_out) >= $signed(V_THRESH));
   end

   // Issue index holds at the last neuron after RUN so stim_addr keeps its value;
   // it is restarted at 0 on the next step.
   always_comb begin
      state_d     = state_q;
      init_idx_d  = init_idx_q;
      issue_idx_d = issue_idx_q;
      case (state_q)
         INIT: begin
            if (init_idx_q == LAST_IDX) begin
               init_idx_d = '0;
               state_d    = IDLE;
            end else begin
               init_idx_d = init_idx_q + IDX_W'(1);
            end
         end
         IDLE: begin
            if (step_start) begin
               issue_idx_d = '0;
               state_d     = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (issue_idx_q == LAST_IDX) begin
               state_d = DRAIN;
            end else begin
               issue_idx_d = issue_idx_q + IDX_W'(1);
            end
         end
         DRAIN: begin
            if (!pipe_busy_s) begin
               state_d = DONE;
            end else begin
               state_d = DRAIN;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = INIT;
      endcase

      step_busy_d    = (state_d != IDLE);
      step_done_d    = (state_d == DONE);
      step_overrun_d = step_start && (state_q != IDLE);
      if (state_d == DONE) begin
         step_count_d = step_count_q + 32'd1;
      end else begin
         step_count_d = step_count_q;
      end
      spike_valid_d = spike_hit_s;
      if (spike_hit_s) begin
         spike_idx_d = tail_s.idx;
      end else begin
         spike_idx_d = spike_idx_q;
      end
   end

   always_comb begin
      ram_re_s = (state_q == RUN);
      if (state_q == INIT) begin
         ram_we_s    = 1'b1;
         ram_waddr_s = init_idx_q;
         ram_wdata_s = {V_INIT, W_INIT};
      end else begin
         ram_we_s    = tail_s.valid;
         ram_waddr_s = tail_s.idx;
         ram_wdata_s = {core_v_out, core_w_out};
      end
      if (pipe_q[0].valid) begin
         core_i = stim_data;
      end else begin
         core_i = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= INIT;
         init_idx_q     <= '0;
         issue_idx_q    <= '0;
         pipe_q         <= '0;
         step_busy_q    <= 1'b1;
         step_done_q    <= 1'b0;
         step_overrun_q <= 1'b0;
         step_count_q   <= 32'd0;
         spike_valid_q  <= 1'b0;
         spike_idx_q    <= '0;
      end else begin
         state_q        <= state_d;
         init_idx_q     <= init_idx_d;
         issue_idx_q    <= issue_idx_d;
         pipe_q         <= pipe_d;
         step_busy_q    <= step_busy_d;
         step_done_q    <= step_done_d;
         step_overrun_q <= step_overrun_d;
         step_count_q   <= step_count_d;
         spike_valid_q  <= spike_valid_d;
         spike_idx_q    <= spike_idx_d;
      end
   end

   tdm_state_ram #(
      .DEPTH (NEURON_COUNT),
      .WIDTH (2*DATA_W),
      .AW    (IDX_W)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (ram_we_s),
      .waddr (ram_waddr_s),
      .wdata (ram_wdata_s),
      .re    (ram_re_s),
      .raddr (issue_idx_q),
      .rdata (ram_rdata_s)
   );

   assign step_busy    = step_busy_q;
   assign step_done    = step_done_q;
   assign step_overrun = step_overrun_q;
   assign step_count   = step_count_q;
   assign stim_addr    = issue_idx_q;
   assign core_valid   = pipe_q[0].valid;
   assign core_v       = ram_rdata_s[2*DATA_W-1:DATA_W];
   assign core_w       = ram_rdata_s[DATA_W-1:0];
   assign spike_valid  = spike_valid_q;
   assign spike_idx    = spike_idx_q;

`ifdef TDM_MONITOR_EN
   logic              mon_valid_q, mon_valid_d;
   logic [DATA_W-1:0] mon_v_q, mon_v_d, mon_w_q, mon_w_d;

   always_comb begin
      mon_valid_d = tail_s.valid && (tail_s.idx == monitor_id);
      if (mon_valid_d) begin
         mon_v_d = core_v_out;
         mon_w_d = core_w_out;
      end else begin
         mon_v_d = mon_v_q;
         mon_w_d = mon_w_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mon_valid_q <= 1'b0;
         mon_v_q     <= '0;
         mon_w_q     <= '0;
      end else begin
         mon_valid_q <= mon_valid_d;
         mon_v_q     <= mon_v_d;
         mon_w_q     <= mon_w_d;
      end
   end

   assign mon_valid = mon_valid_q;
   assign mon_v     = mon_v_q;
   assign mon_w     = mon_w_q;
`endif

endmodule

// File: tb/tb_tdm_neuron_scheduler.sv
// Directed self-checking bench for tdm_neuron_scheduler (N=8, PIPE_DEPTH=3).
// Honours TDM_MONITOR_EN to exercise the monitor port when it is built in.
module tb_tdm_neuron_scheduler;

   localparam int N  = 8;
   localparam int P  = 3;
   localparam int DW = 16;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          step_start = 1'b0;
   logic          step_busy, step_done, step_overrun;
   logic [31:0]   step_count;
   logic [IW-1:0] stim_addr;
   logic [DW-1:0] stim_data = 16'h0000;
   logic          core_valid;
   logic [DW-1:0] core_v, core_w, core_i, core_v_out, core_w_out;
   logic          spike_valid;
   logic [IW-1:0] spike_idx;
`ifdef TDM_MONITOR_EN
   logic [IW-1:0] monitor_id = 3'd6;
   logic [DW-1:0] mon_v, mon_w;
   logic          mon_valid;
`endif

   int checks = 0;
   int errors = 0;
   int exp_count = 0;

   logic          zero_mode = 1'b0;
   logic          ramp_mode = 1'b0;
   logic [DW-1:0] dv [P];
   logic [DW-1:0] dw [P];

   always #5 clk = ~clk;

   // Stimulus source: one cycle behind stim_addr. Core: P-stage delay line, v+i / w.
   always @(posedge clk) begin
      stim_data <= ramp_mode ? (16'(stim_addr) << 11) : 16'h0001;
      dv[0]     <= zero_mode ? 16'h0000 : core_v + core_i;
      dw[0]     <= core_w;
      for (int j = 1; j < P; j++) begin
         dv[j] <= dv[j-1];
         dw[j] <= dw[j-1];
      end
   end
   assign core_v_out = dv[P-1];
   assign core_w_out = dw[P-1];

   tdm_neuron_scheduler #(
      .NEURON_COUNT (N),
      .PIPE_DEPTH   (P),
      .DATA_W       (DW),
      .V_INIT       (16'hECE1),
      .W_INIT       (16'hF600),
      .V_THRESH     (16'h1E00)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .step_start   (step_start),
      .step_busy    (step_busy),
      .step_done    (step_done),
      .step_overrun (step_overrun),
      .step_count   (step_count),
      .stim_addr    (stim_addr),
      .stim_data    (stim_data),
      .core_valid   (core_valid),
      .core_v       (core_v),
      .core_w       (core_w),
      .core_i       (core_i),
      .core_v_out   (core_v_out),
      .core_w_out   (core_w_out),
      .spike_valid  (spike_valid),
      .spike_idx    (spike_idx)
`ifdef TDM_MONITOR_EN
      ,.monitor_id  (monitor_id)
      ,.mon_v       (mon_v)
      ,.mon_w       (mon_w)
      ,.mon_valid   (mon_valid)
`endif
   );

   // Pulse step_start from IDLE and return edges until step_done (0 on timeout).
   task automatic run_step(output int cyc);
      cyc = 0;
      @(negedge clk);
      @(negedge clk);
      step_start = 1'b1;
      @(posedge clk);
      #1 step_start = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk);
         #1;
         if (step_done) begin
            cyc = c;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int cnt;
      logic [31:0] word;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (step_busy !== 1'b1 || step_done !== 1'b0 || step_overrun !== 1'b0 ||
          step_count !== 32'd0 || core_valid !== 1'b0 || spike_valid !== 1'b0 ||
          stim_addr !== 3'd0) begin
         errors++;
         $display("FAIL reset_outputs busy=%b done=%b ovr=%b cnt=%0d cv=%b spk=%b addr=%0d required busy=1 rest 0",
                  step_busy, step_done, step_overrun, step_count, core_valid, spike_valid, stim_addr);
      end
      rst = 1'b0;
      cnt = 0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         cnt = c;
         if (!step_busy) break;
      end
      checks++;
      if (cnt !== 8) begin
         errors++;
         $display("FAIL init_length got %0d edges required 8", cnt);
      end
      for (int i = 0; i < N; i++) begin
         word = dut.u_ram.mem_q[i];
         checks++;
         if (word !== 32'hECE1F600) begin
            errors++;
            $display("FAIL init_ram[%0d] got %h required ece1f600", i, word);
         end
      end
   endtask

   task automatic test_unit_step();
      int cyc, ncv;
      logic [31:0] word;
      ncv = 0;
      @(negedge clk);
      @(negedge clk);
      step_start = 1'b1;
      @(posedge clk);
      #1 step_start = 1'b0;
      cyc = 0;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk);
         #1;
         if (core_valid) ncv++;
         if (step_done) begin
            cyc = c;
            break;
         end
      end
      exp_count++;
      checks++;
      if (cyc !== 12) begin
         errors++;
         $display("FAIL step_latency got %0d required 12", cyc);
      end
      checks++;
      if (ncv !== 8) begin
         errors++;
         $display("FAIL core_valid_count got %0d required 8", ncv);
      end
      checks++;
      if (step_count !== 32'd1) begin
         errors++;
         $display("FAIL step_count_1 got %0d required 1", step_count);
      end
      @(posedge clk);
      #1;
      checks++;
      if (step_done !== 1'b0 || step_busy !== 1'b0 || stim_addr !== 3'd7) begin
         errors++;
         $display("FAIL after_done done=%b busy=%b addr=%0d required 0 0 7", step_done, step_busy, stim_addr);
      end
      for (int i = 0; i < N; i++) begin
         word = dut.u_ram.mem_q[i];
         checks++;
         if (word !== 32'hECE2F600) begin
            errors++;
            $display("FAIL unit_ram[%0d] got %h required ece2f600", i, word);
         end
      end
   endtask

   task automatic test_spike();
      int cyc;
      logic exp_spk;
      logic [31:0] word, exp_word;
      zero_mode = 1'b1;
      run_step(cyc);
      exp_count++;
      checks++;
      if (cyc !== 12) begin
         errors++;
         $display("FAIL preset_latency got %0d required 12", cyc);
      end
      zero_mode = 1'b0;
      ramp_mode = 1'b1;
      @(negedge clk);
      @(negedge clk);
      step_start = 1'b1;
      @(posedge clk);
      #1 step_start = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         @(posedge clk);
         #1;
         exp_spk = (c >= 9 && c <= 12);
         checks++;
         if (spike_valid !== exp_spk || (exp_spk && spike_idx !== 3'(c - 5))) begin
            errors++;
            $display("FAIL spike_c%0d got valid=%b idx=%0d required valid=%b idx=%0d",
                     c, spike_valid, spike_idx, exp_spk, c - 5);
         end
      end
      exp_count++;
      checks++;
      if (step_count !== 32'(exp_count)) begin
         errors++;
         $display("FAIL spike_step_count got %0d required %0d", step_count, exp_count);
      end
      for (int i = 0; i < N; i++) begin
         word     = dut.u_ram.mem_q[i];
         exp_word = {16'(i) << 11, 16'hF600};
         checks++;
         if (word !== exp_word) begin
            errors++;
            $display("FAIL ramp_ram[%0d] got %h required %h", i, word, exp_word);
         end
      end
      ramp_mode = 1'b0;
   endtask

`ifdef TDM_MONITOR_EN
   task automatic test_monitor();
      int nmon;
      nmon = 0;
      @(negedge clk);
      @(negedge clk);
      step_start = 1'b1;
      @(posedge clk);
      #1 step_start = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         @(posedge clk);
         #1;
         if (mon_valid) nmon++;
      end
      exp_count++;
      checks++;
      if (nmon !== 1) begin
         errors++;
         $display("FAIL mon_pulses got %0d required 1", nmon);
      end
      checks++;
      if (mon_v !== 16'h3001 || mon_w !== 16'hF600 || {mon_v, mon_w} !== dut.u_ram.mem_q[6]) begin
         errors++;
         $display("FAIL mon_value got %h/%h required 3001/f600", mon_v, mon_w);
      end
   endtask
`endif

   task automatic test_back_to_back();
      int ndone;
      logic exp_done, exp_ovr;
      ndone = 0;
      @(negedge clk);
      step_start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 41; c++) begin
         @(posedge clk);
         #1;
         exp_done = ((c % 14) == 12);
         exp_ovr  = ((c % 14) != 0);
         if (step_done) ndone++;
         checks++;
         if (step_done !== exp_done || step_overrun !== exp_ovr) begin
            errors++;
            $display("FAIL b2b_c%0d got done=%b ovr=%b required done=%b ovr=%b",
                     c, step_done, step_overrun, exp_done, exp_ovr);
         end
      end
      step_start = 1'b0;
      exp_count = exp_count + 3;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (ndone !== 3 || step_count !== 32'(exp_count) || step_busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_total got dones=%0d cnt=%0d busy=%b required 3 %0d 0",
                  ndone, step_count, step_busy, exp_count);
      end
   endtask

   task automatic test_reset_mid_run();
      int cnt, ndone;
      logic [31:0] word;
      ndone = 0;
      @(negedge clk);
      step_start = 1'b1;
      @(posedge clk);
      #1 step_start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (stim_addr !== 3'd5 || step_busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_run_pos got addr=%0d busy=%b required 5 1", stim_addr, step_busy);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (step_busy !== 1'b1 || step_done !== 1'b0 || step_count !== 32'd0 ||
          core_valid !== 1'b0 || stim_addr !== 3'd0 || spike_valid !== 1'b0) begin
         errors++;
         $display("FAIL async_clear busy=%b done=%b cnt=%0d cv=%b addr=%0d spk=%b required 1 0 0 0 0 0",
                  step_busy, step_done, step_count, core_valid, stim_addr, spike_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         cnt = c;
         if (step_done) ndone++;
         if (!step_busy) break;
      end
      repeat (4) @(posedge clk);
      #1;
      if (step_done) ndone++;
      checks++;
      if (cnt !== 8 || ndone !== 0 || step_count !== 32'd0) begin
         errors++;
         $display("FAIL reinit got edges=%0d dones=%0d cnt=%0d required 8 0 0", cnt, ndone, step_count);
      end
      for (int i = 0; i < N; i++) begin
         word = dut.u_ram.mem_q[i];
         checks++;
         if (word !== 32'hECE1F600) begin
            errors++;
            $display("FAIL reinit_ram[%0d] got %h required ece1f600", i, word);
         end
      end
   endtask

   initial begin
      test_reset();
      test_unit_step();
      test_spike();
`ifdef TDM_MONITOR_EN
      test_monitor();
`endif
      test_back_to_back();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
